// File: rtl/time_set_ctrl.sv
// Clock/time-of-day register set with a mode button that walks through the
// hour/minute/second edit fields. Editing supports single steps, auto-repeat and a tick-based timeout.
module time_set_ctrl #(
  parameter int HOLD_CYC      = 500,
  parameter int REP_CYC       = 100,  // must not exceed HOLD_CYC
  parameter int TIMEOUT_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  output logic [6:0] h,
  output logic [6:0] m,
  output logic [6:0] s,
  output logic       editing,
  output logic [1:0] field
);

  typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2, SET_S = 2'd3} state_t;

  localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC + 1) : 1;
  localparam int TW = (TIMEOUT_TICKS > 1) ? $clog2(TIMEOUT_TICKS + 1) : 1;
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLD_CYC);
  localparam logic [HW-1:0] REP_RELOAD = HW'(HOLD_CYC - REP_CYC + 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_TICKS - 1);

  state_t          r_state;
  logic            r_editing;
  logic [6:0]      r_h, r_m, r_s;
  logic [HW-1:0]   r_hold;
  logic [TW-1:0]   r_to;
  logic            r_prev_mode, r_prev_inc, r_prev_dec;
  logic            r_arm_mode, r_arm_inc, r_arm_dec;

  // A button held through reset stays disarmed until it has been seen released.
  logic w_edge_mode, w_edge_inc, w_edge_dec, w_single, w_rep, w_step, w_btn_evt;
  assign w_edge_mode = btn_mode & ~r_prev_mode & r_arm_mode;
  assign w_edge_inc  = btn_inc  & ~r_prev_inc  & r_arm_inc;
  assign w_edge_dec  = btn_dec  & ~r_prev_dec  & r_arm_dec;
  assign w_single    = btn_inc ^ btn_dec;
  assign w_rep       = w_single & ~w_edge_inc & ~w_edge_dec & (r_hold == HOLD_MAX);
  assign w_step      = w_single & (w_edge_inc | w_edge_dec | w_rep);
  assign w_btn_evt   = w_edge_inc | w_edge_dec | w_rep;

  function automatic logic [6:0] step_val(input logic [6:0] v, input logic [6:0] max_v,
                                          input logic up);
    if (up) return (v == max_v) ? 7'd0 : v + 7'd1;
    else    return (v == 7'd0) ? max_v : v - 7'd1;
  endfunction

  // NOTE: all state lives in one clocked block with non-blocking updates, so later
  // assignments in the same cycle (e.g. a timeout clearing r_hold) simply win.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_editing   <= 1'b0;
      r_h         <= 7'd0;
      r_m         <= 7'd0;
      r_s         <= 7'd0;
      r_hold      <= '0;
      r_to        <= '0;
      r_prev_mode <= 1'b0;
      r_prev_inc  <= 1'b0;
      r_prev_dec  <= 1'b0;
      r_arm_mode  <= ~btn_mode;
      r_arm_inc   <= ~btn_inc;
      r_arm_dec   <= ~btn_dec;
    end else begin
      r_prev_mode <= btn_mode;
      r_prev_inc  <= btn_inc;
      r_prev_dec  <= btn_dec;
      r_arm_mode  <= r_arm_mode | ~btn_mode;
      r_arm_inc   <= r_arm_inc  | ~btn_inc;
      r_arm_dec   <= r_arm_dec  | ~btn_dec;

      if (r_state == RUN) begin
        r_hold <= '0;
        r_to   <= '0;
        if (w_edge_mode) begin
          r_state   <= SET_H;
          r_editing <= 1'b1;
        end else if (tick) begin
          if (r_s == 7'd59) begin
            r_s <= 7'd0;
            if (r_m == 7'd59) begin
              r_m <= 7'd0;
              r_h <= (r_h == 7'd23) ? 7'd0 : r_h + 7'd1;
            end else begin
              r_m <= r_m + 7'd1;
            end
          end else begin
            r_s <= r_s + 7'd1;
          end
        end
      end else if (w_edge_mode) begin
        r_hold <= '0;
        r_to   <= '0;
        case (r_state)
          SET_H:   r_state <= SET_M;
          SET_M:   r_state <= SET_S;
          default: begin
            r_state   <= RUN;
            r_editing <= 1'b0;
          end
        endcase
      end else begin
        // r_hold == 0 means no repeat run is active; a run only starts on a clean edge.
        if (!w_single)                    r_hold <= '0;
        else if (w_edge_inc | w_edge_dec) r_hold <= HW'(1);
        else if (r_hold == '0)            r_hold <= '0;
        else if (r_hold == HOLD_MAX)      r_hold <= REP_RELOAD;
        else                              r_hold <= r_hold + HW'(1);

        if (w_step) begin
          case (r_state)
            SET_H:   r_h <= step_val(r_h, 7'd23, btn_inc);
            SET_M:   r_m <= step_val(r_m, 7'd59, btn_inc);
            default: r_s <= step_val(r_s, 7'd59, btn_inc);
          endcase
        end

        if (w_btn_evt) begin
          r_to <= '0;
        end else if (tick) begin
          if (r_to == TO_LAST) begin
            r_state   <= RUN;
            r_editing <= 1'b0;
            r_hold    <= '0;
            r_to      <= '0;
          end else begin
            r_to <= r_to + TW'(1);
          end
        end
      end
    end
  end

  assign h       = r_h;
  assign m       = r_m;
  assign s       = r_s;
  assign editing = r_editing;
  assign field   = r_state;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: carry chain, edit/wrap, auto-repeat,
// simultaneous-button rules, timeout and reset behaviour with held buttons.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick, btn_mode, btn_inc, btn_dec;
  logic [6:0] h, m, s;
  logic       editing;
  logic [1:0] field;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(.HOLD_CYC(500), .REP_CYC(100), .TIMEOUT_TICKS(10)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .btn_mode (btn_mode),
    .btn_inc  (btn_inc),
    .btn_dec  (btn_dec),
    .h        (h),
    .m        (m),
    .s        (s),
    .editing  (editing),
    .field    (field)
  );

  // Advance n rising edges, then settle 1 ns past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_time(input string tag, input int eh, input int em, input int es);
    check({tag, ".h"}, 32'(h), eh);
    check({tag, ".m"}, 32'(m), em);
    check({tag, ".s"}, 32'(s), es);
  endtask

  task automatic press(input logic pm, input logic pi, input logic pd);
    btn_mode = pm; btn_inc = pi; btn_dec = pd;
    cyc(1);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cyc(1);
  endtask

  task automatic tick1();
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(1);
    check_time("reset", 0, 0, 0);
    check("reset.field", 32'(field), 0);
    check("reset.editing", 32'(editing), 0);

    press(0, 1, 0);
    press(0, 0, 1);
    check_time("run_inc_dec_ignored", 0, 0, 0);

    // Build 23:59:58 by decrement wraps in each field.
    press(1, 0, 0);
    check("seth.field", 32'(field), 1);
    check("seth.editing", 32'(editing), 1);
    press(0, 0, 1);
    check("h_dec_wrap", 32'(h), 23);
    press(0, 1, 0);
    check("h_inc_wrap", 32'(h), 0);
    press(0, 0, 1);
    press(1, 0, 0);
    check("setm.field", 32'(field), 2);
    press(0, 0, 1);
    press(1, 0, 0);
    check("sets.field", 32'(field), 3);
    press(0, 0, 1);
    press(0, 0, 1);
    check_time("set_235958", 23, 59, 58);
    press(1, 0, 0);
    check("back_run.field", 32'(field), 0);
    check("back_run.editing", 32'(editing), 0);
    tick1();
    check_time("tick_235959", 23, 59, 59);
    tick1();
    check_time("tick_rollover", 0, 0, 0);

    // Minute edit with decrement wrap, ticks ignored while editing.
    press(1, 0, 0);
    press(1, 0, 0);
    check("m_edit.field", 32'(field), 2);
    check("m_edit.editing", 32'(editing), 1);
    press(0, 0, 1);
    check_time("m_dec_wrap", 0, 59, 0);
    repeat (5) tick1();
    check_time("set_ticks_discarded", 0, 59, 0);
    check("set_ticks.field", 32'(field), 2);

    // Timeout: ten ticks with no button activity.
    press(0, 1, 0);
    check_time("m_inc_wrap", 0, 0, 0);
    repeat (9) tick1();
    check("timeout_9.field", 32'(field), 2);
    tick1();
    check("timeout_10.field", 32'(field), 0);
    check("timeout_10.editing", 32'(editing), 0);
    check_time("timeout_retained", 0, 0, 0);
    tick1();
    check_time("tick_after_timeout", 0, 0, 1);

    // Simultaneous-button rules in SET_S.
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 0);
    check("sets2.field", 32'(field), 3);
    press(0, 1, 1);
    check_time("inc_dec_together", 0, 0, 1);
    press(1, 1, 0);
    check("mode_inc_together.field", 32'(field), 0);
    check_time("mode_inc_together", 0, 0, 1);

    // Auto-repeat on hours from 22.
    press(1, 0, 0);
    press(0, 0, 1);
    press(0, 0, 1);
    check("rep_start_h", 32'(h), 22);
    btn_inc = 1'b1;
    cyc(1);
    check("rep_cycle0", 32'(h), 23);
    cyc(499);
    check("rep_cycle499", 32'(h), 23);
    cyc(1);
    check("rep_cycle500", 32'(h), 0);
    cyc(99);
    check("rep_cycle599", 32'(h), 0);
    cyc(1);
    check("rep_cycle600", 32'(h), 1);
    cyc(99);
    btn_inc = 1'b0;
    cyc(1);
    check("rep_released", 32'(h), 1);
    check("rep.field", 32'(field), 1);

    // Reset mid-edit with buttons held across it.
    btn_inc = 1'b1;
    cyc(1);
    check("pre_rst_step", 32'(h), 2);
    btn_mode = 1'b1;
    rst = 1'b1;
    cyc(1);
    check_time("rst_mid_edit", 0, 0, 0);
    check("rst_mid_edit.field", 32'(field), 0);
    check("rst_mid_edit.editing", 32'(editing), 0);
    rst = 1'b0;
    cyc(600);
    check_time("held_after_rst", 0, 0, 0);
    check("held_mode_after_rst.field", 32'(field), 0);
    btn_mode = 1'b0;
    cyc(1);
    btn_mode = 1'b1;
    cyc(1);
    btn_mode = 1'b0;
    check("repress_mode.field", 32'(field), 1);
    cyc(600);
    check("held_inc_no_repeat", 32'(h), 0);
    btn_inc = 1'b0;
    cyc(1);
    press(0, 1, 0);
    check("repress_inc", 32'(h), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 Parameter HOLD_CYC, default 500, clk cycles a step button must be held before auto-repeat starts.
REQ-002 Parameter REP_CYC, default 100, clk cycles between auto-repeat steps.
REQ-003 Parameter TIMEOUT_TICKS, default 10, tick pulses without a button edge before SET states return to RUN.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 tick  input  1  one-cycle 1 Hz time-base enable.
REQ-007 btn_mode  input  1  mode/field-select button level, synchronous to clk.
REQ-008 btn_inc  input  1  increment button level, synchronous to clk.
REQ-009 btn_dec  input  1  decrement button level, synchronous to clk.
REQ-010 h  output  7  hours, 0..23.
REQ-011 m  output  7  minutes, 0..59.
REQ-012 s  output  7  seconds, 0..59.
REQ-013 editing  output  1  high in any SET state.
REQ-014 field  output  2  0=RUN, 1=SET_H, 2=SET_M, 3=SET_S.

Function
REQ-015 Button edge = current sample 1 and previous registered sample 0; each button has its own previous-sample register.
REQ-016 FSM states RUN, SET_H, SET_M, SET_S; btn_mode edge advances RUN->SET_H->SET_M->SET_S->RUN.
REQ-017 State change and field output update on the same clk edge that detects the btn_mode edge.
REQ-018 RUN: tick increments s; s 59->0 carries m+1; m 59->0 carries h+1; h 23->0; full carry chain in one cycle (23:59:59 -> 00:00:00).
REQ-019 SET states: tick never advances time; ticks during SET are discarded, not accumulated.
REQ-020 SET state, btn_inc edge: selected field +1, wrap at max (h 23->0, m/s 59->0), no carry into other fields.
REQ-021 SET state, btn_dec edge: selected field -1, wrap at 0 (h 0->23, m/s 0->59), no borrow.
REQ-022 Step visible on outputs after the clk edge that detects the button edge.
REQ-023 btn_inc and btn_dec both high in the same cycle: no step; hold counter cleared.
REQ-024 btn_mode edge coinciding with inc/dec edge: mode transition only, step ignored.
REQ-025 Auto-repeat: single button held in SET; after HOLD_CYC cycles from the edge cycle, one further step, then one step every REP_CYC cycles while held.
REQ-026 Releasing the button or changing state clears the hold counter.
REQ-027 btn_inc/btn_dec in RUN: no effect on time.
REQ-028 Timeout: in SET, count ticks since last button edge or auto-repeat step; at TIMEOUT_TICKS return to RUN; time values retained.
REQ-029 Timeout counter cleared on every SET entry and every button edge.
REQ-030 On SET->RUN, first counted tick is the next tick after the transition.
REQ-031 Outputs come directly from registers; no combinational path from inputs to outputs.

Reset
REQ-032 rst high at a clk edge: h=m=s=0, state RUN, editing=0, field=0, hold/timeout counters 0, previous-sample registers 0.
REQ-033 rst overrides all inputs in the same cycle, including mid-edit and mid-auto-repeat.
REQ-034 A button already held when rst deasserts does not cause an edge until released and pressed again.

Verification
REQ-035 23:59:58, two ticks in RUN -> 23:59:59 then 00:00:00.
REQ-036 From RUN, mode edge x2 -> field=2, editing=1; dec edge at m=0 -> m=59, h unchanged; 5 ticks -> s unchanged.
REQ-037 SET_H, h=22, btn_inc held 700 cycles (HOLD_CYC=500, REP_CYC=100) -> steps at cycles 0, 500, 600 -> h=23, 0, 1.
REQ-038 SET_S, inc and dec asserted together -> s unchanged; mode and inc edges together -> field=0, s unchanged.
REQ-039 SET_M, no button, 10 ticks -> field=0 after 10th tick; 11th tick -> s+1.
REQ-040 rst during SET_H with btn_inc held -> 00:00:00, field=0; btn_inc kept high after rst -> no change.
